multiword_add_seq: RTL

- Sequential multi-word adder/subtractor for operands wider than the team's 32-bit word adder.
- Accepts one wide operand pair through a valid/ready handshake.
- Feeds one WORD_W slice per cycle, LSB first, into a combinational word adder, and consumes its sum and carry-out. The carry is registered between slices.
- Returns the full-width sum, carry-out and signed overflow through a valid/ready handshake.

---
 rtl/add_pkg.sv | 19 +
 rtl/word_adder.sv | 18 +
 rtl/multiword_add_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/add_pkg.sv
// Shared definitions for the sequential multi-word adder: FSM states,
// default slice width and the signed-overflow rule.
package add_pkg;

  localparam int DEFAULT_WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two's-complement overflow: operands agree in sign but the result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/word_adder.sv
// Combinational WORD_W-bit adder with full carry-in to carry-out propagation.
module word_adder #(
  parameter int WORD_W = add_pkg::DEFAULT_WORD_W
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  logic [WORD_W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};
  assign sum  = full[WORD_W-1:0];
  assign cout = full[WORD_W];

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential W-bit add/subtract built from one WORD_W adder reused LSB-first
// over NUM_WORDS slices, with valid/ready handshakes on input and output.
module multiword_add_seq
  import add_pkg::*;
#(
  parameter int WORD_W    = DEFAULT_WORD_W,
  parameter int NUM_WORDS = 4,
  localparam int W        = WORD_W * NUM_WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid, once raised, holds its payload stable until that edge.

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [WORD_W-1:0] wa_a, wa_b, wa_sum;
  logic              wa_cout;

  assign wa_a = a_q[idx_q*WORD_W +: WORD_W];
  assign wa_b = b_q[idx_q*WORD_W +: WORD_W];

  word_adder #(.WORD_W(WORD_W)) u_word_adder (
    .a    (wa_a),
    .b    (wa_b),
    .cin  (carry_q),
    .sum  (wa_sum),
    .cout (wa_cout)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1, so B is inverted once at capture.
          a_d        = in_a;
          b_d        = in_b ^ {W{in_sub}};
          carry_d    = in_sub ? 1'b1 : in_cin;
          idx_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[idx_q*WORD_W +: WORD_W] = wa_sum;
        carry_d = wa_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d      = wa_cout;
          ovf_d       = signed_ovf(a_q[W-1], b_q[W-1], wa_sum[WORD_W-1]);
          idx_d       = '0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule
